h14tx_island_scheduler: RTL and testbench

//  Data-island scheduler for the HDMI 1.4 TX. Arbitrates NUM_SRC packet sources (ACR, AVI, audio, ...)
//  and sequences each blanking interval into ctl -> preamble -> guard band -> N x 32-clk packets -> guard band.

---
 rtl/h14tx_pkg.sv | 33 +++
 rtl/h14tx_src_arbiter.sv | 28 ++
 rtl/h14tx_island_scheduler.sv | 175 +++++++++++++++++
 tb/tb_h14tx_island_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 TX types: packet container, TMDS period code and
// data-island scheduler state encoding.
package h14tx_pkg;

  // 3 header bytes plus 4 subpackets of 7 bytes each
  typedef struct packed {
    logic [23:0]  hb;
    logic [223:0] pb;
  } packet_t;

  localparam packet_t PKT_NULL = '{hb: '0, pb: '0};

  // Period code consumed by the TMDS encoder mux
  typedef enum logic [1:0] {
    PER_CTL     = 2'd0,
    PER_DI_PRE  = 2'd1,
    PER_DI_GB   = 2'd2,
    PER_DI_DATA = 2'd3
  } period_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LGB  = 3'd2,
    ST_DATA = 3'd3,
    ST_TGB  = 3'd4
  } sched_state_t;

  localparam int PRE_LEN  = 8;
  localparam int GB_LEN   = 2;
  localparam int SLOT_LEN = 32;

endpackage

// File: rtl/h14tx_src_arbiter.sv
// Packet source arbiter: picks one pending requester, searching upward
// from ptr with wrap-around. Holding ptr at zero gives fixed priority.
module h14tx_src_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] grant,
  output logic               valid
);

  // First requester at or after ptr wins
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/h14tx_island_scheduler.sv
// HDMI 1.4 TX data-island scheduler. Turns an eligible blanking interval
// into preamble, leading guard band, n 32-clock packet slots and a
// trailing guard band, pulling one packet per slot from the sources.
// Optional feature: define H14TX_SCHED_RR_EN for round-robin arbitration
// (default build uses fixed priority, lowest index wins).
module h14tx_island_scheduler
  import h14tx_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int MAX_PKTS    = 18,
  parameter int DI_OVERHEAD = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                blank_start,
  input  logic [11:0]         blank_len,
  input  logic [NUM_SRC-1:0]  req,
  input  packet_t             pkt_in [NUM_SRC],
  output logic [NUM_SRC-1:0]  ack,
  output packet_t             packet,
  output logic                asm_active,
  output period_t             period
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  sched_state_t       state;
  sched_state_t       state_nxt;
  logic [2:0]         phase;
  logic [4:0]         slot;
  logic [4:0]         pkt_cnt;
  logic [4:0]         n_lat;
  logic [4:0]         pop_cnt;
  logic [11:0]        fit;
  logic [4:0]         n_calc;
  logic               accept;
  logic               slot_start;
  logic [NUM_SRC-1:0] grant;
  logic               grant_vld;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   rr_ptr;

  // Number of pending sources
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop_cnt = pop_cnt + 5'(req[i]);
    end
  end

  // Island length: min(pending, packets that fit, MAX_PKTS)
  always_comb begin
    fit = 12'd0;
    if (blank_len >= 12'(DI_OVERHEAD + SLOT_LEN)) begin
      fit = (blank_len - 12'(DI_OVERHEAD)) >> 5;
    end
    n_calc = pop_cnt;
    if ({7'd0, pop_cnt} > fit) begin
      n_calc = fit[4:0];
    end
    if (n_calc > 5'(MAX_PKTS)) begin
      n_calc = 5'(MAX_PKTS);
    end
  end

  assign accept = (state == ST_IDLE) && blank_start && (n_calc != 5'd0);

  h14tx_src_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .valid (grant_vld)
  );

  // One-hot grant to source index
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) win = IDX_W'(i);
    end
  end

`ifdef H14TX_SCHED_RR_EN
  // Round-robin pointer: next search starts just past the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (slot_start && grant_vld) begin
      rr_ptr <= (win == IDX_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)                          state_nxt = ST_PRE;
      ST_PRE:  if (phase == 3'(PRE_LEN - 1))        state_nxt = ST_LGB;
      ST_LGB:  if (phase == 3'(GB_LEN - 1))         state_nxt = ST_DATA;
      ST_DATA: if (slot == 5'(SLOT_LEN - 1) && pkt_cnt == n_lat)
                                                    state_nxt = ST_TGB;
      ST_TGB:  if (phase == 3'(GB_LEN - 1))         state_nxt = ST_IDLE;
      default:                                      state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: period code, assembler enable and slot-start strobe
  always_comb begin
    period     = PER_CTL;
    asm_active = 1'b0;
    slot_start = 1'b0;
    case (state)
      ST_PRE: period = PER_DI_PRE;
      ST_LGB: begin
        period     = PER_DI_GB;
        slot_start = (phase == 3'(GB_LEN - 1));
      end
      ST_DATA: begin
        period     = PER_DI_DATA;
        asm_active = 1'b1;
        slot_start = (slot == 5'(SLOT_LEN - 1)) && (pkt_cnt != n_lat);
      end
      ST_TGB: period = PER_DI_GB;
      default: ;
    endcase
  end

  // Phase, slot and packet counters; island length latched on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      slot    <= '0;
      pkt_cnt <= '0;
      n_lat   <= '0;
    end else begin
      if (accept) n_lat <= n_calc;
      if (state != state_nxt) begin
        phase <= '0;
      end else if (state == ST_PRE || state == ST_LGB || state == ST_TGB) begin
        phase <= phase + 3'd1;
      end
      if (state == ST_DATA) slot <= slot + 5'd1;
      else                  slot <= '0;
      if (accept)          pkt_cnt <= '0;
      else if (slot_start) pkt_cnt <= pkt_cnt + 5'd1;
    end
  end

  // Latch the winning packet and pulse its ack at each slot start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack    <= '0;
      packet <= PKT_NULL;
    end else begin
      ack <= '0;
      if (slot_start) begin
        ack    <= grant;
        packet <= grant_vld ? pkt_in[win] : PKT_NULL;
      end
    end
  end

endmodule

// File: tb/tb_h14tx_island_scheduler.sv
// Scoreboard bench for h14tx_island_scheduler: stimulus queues expected
// period transitions and acks, a negedge monitor pops and compares them.
module tb_h14tx_island_scheduler;
  import h14tx_pkg::*;

  typedef struct { period_t per; int cyc; } per_exp_t;
  typedef struct { logic [3:0] ack; packet_t pkt; int cyc; } ack_exp_t;

`ifdef H14TX_SCHED_RR_EN
  localparam logic [3:0] EXP_ACK [12] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001,
                                          4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                          4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
  localparam logic [3:0] EXP_ACK [12] = '{4'b0001, 4'b0001, 4'b0010, 4'b1000,
                                          4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                          4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blank_start;
  logic [11:0] blank_len;
  logic [3:0]  req;
  packet_t     pkts [4];
  logic [3:0]  ack;
  packet_t     packet;
  logic        asm_active;
  period_t     period;

  logic [3:0]  pend = 4'b0;
  logic [3:0]  raise;
  logic [3:0]  drop;
  logic        want_rst_chk;
  logic        want_idle_chk;
  logic        want_empty_chk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ai = 0;
  per_exp_t    per_q [$];
  ack_exp_t    ack_q [$];
  per_exp_t    pe;
  ack_exp_t    ae;
  period_t     prev_per = PER_CTL;

  h14tx_island_scheduler #(
    .NUM_SRC     (4),
    .MAX_PKTS    (18),
    .DI_OVERHEAD (24)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .blank_start (blank_start),
    .blank_len   (blank_len),
    .req         (req),
    .pkt_in      (pkts),
    .ack         (ack),
    .packet      (packet),
    .asm_active  (asm_active),
    .period      (period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source model: requests held until acked, raised/dropped on command
  always @(posedge clk) pend <= ((pend | raise) & ~drop) & ~ack;
  assign req = pend;

  function automatic int oh2i(input logic [3:0] m);
    oh2i = 0;
    for (int i = 0; i < 4; i++) if (m[i]) oh2i = i;
  endfunction

  // Monitor: compare DUT outputs against the scoreboard queues
  always @(negedge clk) begin
    if (period !== prev_per) begin
      checks++;
      if (per_q.size() == 0) begin
        errors++;
        $display("FAIL period_unexpected: got %0d at cycle %0d, want no change", period, cyc);
      end else begin
        pe = per_q.pop_front();
        if (period !== pe.per || cyc != pe.cyc) begin
          errors++;
          $display("FAIL period_seq: got %0d at cycle %0d, want %0d at cycle %0d",
                   period, cyc, pe.per, pe.cyc);
        end
        checks++;
        if (asm_active !== (pe.per == PER_DI_DATA)) begin
          errors++;
          $display("FAIL asm_active: got %b at cycle %0d, want %b",
                   asm_active, cyc, (pe.per == PER_DI_DATA));
        end
      end
      prev_per = period;
    end
    if (ack !== 4'b0000) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: got %b at cycle %0d, want none", ack, cyc);
      end else begin
        ae = ack_q.pop_front();
        if (ack !== ae.ack || cyc != ae.cyc) begin
          errors++;
          $display("FAIL ack_seq: got %b at cycle %0d, want %b at cycle %0d",
                   ack, cyc, ae.ack, ae.cyc);
        end
        checks++;
        if (packet !== ae.pkt) begin
          errors++;
          $display("FAIL packet_hb: got %h at cycle %0d, want %h", packet.hb, cyc, ae.pkt.hb);
        end
      end
    end
    if (want_rst_chk) begin
      checks += 4;
      if (period !== PER_CTL) begin
        errors++; $display("FAIL rst_period: got %0d want %0d", period, PER_CTL);
      end
      if (ack !== 4'b0000) begin
        errors++; $display("FAIL rst_ack: got %b want 0000", ack);
      end
      if (asm_active !== 1'b0) begin
        errors++; $display("FAIL rst_asm_active: got %b want 0", asm_active);
      end
      if (packet !== PKT_NULL) begin
        errors++; $display("FAIL rst_packet: got hb %h want null", packet.hb);
      end
    end
    if (want_idle_chk) begin
      checks += 2;
      if (period !== PER_CTL) begin
        errors++; $display("FAIL idle_period: got %0d want %0d", period, PER_CTL);
      end
      if (asm_active !== 1'b0) begin
        errors++; $display("FAIL idle_asm_active: got %b want 0", asm_active);
      end
    end
    if (want_empty_chk) begin
      checks += 2;
      if (per_q.size() != 0) begin
        errors++; $display("FAIL period_pending: got %0d left want 0", per_q.size());
      end
      if (ack_q.size() != 0) begin
        errors++; $display("FAIL ack_pending: got %0d left want 0", ack_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ack(input int c);
    logic [3:0] m;
    m = EXP_ACK[ai];
    ack_q.push_back('{m, pkts[oh2i(m)], c});
    ai++;
  endtask

  task automatic push_island(input int t, input int n);
    per_q.push_back('{PER_DI_PRE,  t + 1});
    per_q.push_back('{PER_DI_GB,   t + 9});
    per_q.push_back('{PER_DI_DATA, t + 11});
    per_q.push_back('{PER_DI_GB,   t + 11 + 32 * n});
    per_q.push_back('{PER_CTL,     t + 13 + 32 * n});
    for (int k = 0; k < n; k++) push_ack(t + 11 + 32 * k);
  endtask

  task automatic blank(input logic [11:0] len, input int n, output int t);
    tick();
    blank_start = 1'b1;
    blank_len   = len;
    t = cyc;
    if (n > 0) push_island(t, n);
    tick();
    blank_start = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] r, input logic [3:0] d);
    raise = r;
    drop  = d;
    tick();
    raise = 4'b0;
    drop  = 4'b0;
  endtask

  task automatic flag_rst();
    want_rst_chk = 1'b1; tick(); want_rst_chk = 1'b0;
  endtask

  task automatic flag_idle();
    want_idle_chk = 1'b1; tick(); want_idle_chk = 1'b0;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((per_q.size() != 0 || ack_q.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    repeat (3) tick();
    want_empty_chk = 1'b1; tick(); want_empty_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int i = 0; i < 4; i++) begin
      pkts[i].hb = 24'hA50000 | 24'(i);
      pkts[i].pb = {7{32'hC0DE0000 | 32'(i)}};
    end
    rst_n = 1'b1; blank_start = 1'b0; blank_len = 12'd0;
    raise = 4'b0; drop = 4'b0;
    want_rst_chk = 1'b0; want_idle_chk = 1'b0; want_empty_chk = 1'b0;
    #2;
    // Reset held with all sources requesting
    rst_n = 1'b0;
    raise = 4'b1111;
    repeat (3) tick();
    flag_rst();
    set_req(4'b0001, 4'b1110);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single packet island, fit=2, n=1
    blank(12'd100, 1, t);
    drain(100);

    // Three sources, n=3
    set_req(4'b1011, 4'b0000);
    blank(12'd400, 3, t);
    drain(200);

    // All four pending but only one slot fits, twice
    set_req(4'b1111, 4'b0000);
    blank(12'd80, 1, t);
    drain(100);
    blank(12'd80, 1, t);
    drain(100);

    // Too short for any packet
    blank(12'd55, 0, t);
    repeat (20) tick();
    flag_idle();

    // blank_start during DATA, on a slot start and during trailing GB is ignored
    blank(12'd400, 2, t);
    wait_to(t + 20); blank_start = 1'b1;
    wait_to(t + 21); blank_start = 1'b0;
    wait_to(t + 42); blank_start = 1'b1;
    wait_to(t + 43); blank_start = 1'b0;
    wait_to(t + 76); blank_start = 1'b1;
    wait_to(t + 77); blank_start = 1'b0;
    drain(150);

    // Async reset in DATA slot 2, cycle 10
    set_req(4'b1111, 4'b0000);
    tick();
    blank_start = 1'b1;
    blank_len   = 12'd400;
    t = cyc;
    per_q.push_back('{PER_DI_PRE,  t + 1});
    per_q.push_back('{PER_DI_GB,   t + 9});
    per_q.push_back('{PER_DI_DATA, t + 11});
    per_q.push_back('{PER_CTL,     t + 85});
    for (int k = 0; k < 3; k++) push_ack(t + 11 + 32 * k);
    tick();
    blank_start = 1'b0;
    wait_to(t + 85);
    rst_n = 1'b0;
    tick();
    flag_rst();
    tick();
    rst_n = 1'b1;
    drain(20);

    // Clean restart after reset: remaining source served
    blank(12'd100, 1, t);
    drain(100);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
